dmem_lsu: RTL and testbench
===========================

Name: dmem_lsu

Overview:
- Load/store initiator that drives the data-memory port from the execute stage.
- Accepts one load or store request at a time.
- Computes the effective address and checks alignment and range.
- Performs read-modify-write for byte/halfword stores, since the memory is word-wide with no byte enables.
- Returns sign/zero-extended load data to writeback over a valid/ready handshake.

Parameters:
- DEPTH_WORDS, 32: number of 32-bit words in data memory. Word index range is 0..DEPTH_WORDS-1.
- IDX_W, 5: width of the significant word-index bits; must equal clog2(DEPTH_WORDS).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  LSU can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU (loads); 000 SB, 001 SH, 010 SW (stores).
- req_base  in  32  rs1 value.
- req_offset  in  12  signed immediate.
- req_wdata  in  32  rs2 value for stores.
- req_rd  in  5  destination register tag, echoed on the response.
- resp_valid  out  1  response present.
- resp_ready  in  1  writeback accepts the response.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_rd  out  5  echoed tag.
- resp_err  out  1  misaligned, out-of-range or illegal funct3.
- mem_access_addr  out  32  word index, zero-extended.
- mem_write_data  out  32  full word to write.
- mem_write_en  out  1  write strobe; memory writes on the clk edge.
- mem_read  out  1  read enable.
- mem_read_data  in  32  combinational read data for the current mem_access_addr.

Behaviour:
- Reset values (async, rst_n=0):
  - state=IDLE, req_ready=1.
  - resp_valid=0, resp_err=0, resp_rdata=0, resp_rd=0.
  - mem_access_addr=0, mem_write_data=0, mem_write_en=0, mem_read=0.
- Reset asserted mid-operation aborts immediately. A write in progress is not performed unless its clk edge precedes the reset assertion.
- Request capture:
  - A request is accepted on a clk edge with req_valid & req_ready.
  - req_ready=1 only in IDLE.
  - All request fields are registered at accept time.
- Effective address: ea = req_base + sign_extend(req_offset), modulo 2^32.
- Word index: idx = ea[31:2]. mem_access_addr = {2'b0, ea[31:2]}.
- Error conditions, evaluated at accept:
  - halfword access with ea[0]=1;
  - word access with ea[1:0]!=0;
  - idx >= DEPTH_WORDS;
  - illegal funct3: 011, 110 or 111 for loads; anything other than 000/001/010 for stores.
  - On error: go straight to RESP with resp_err=1, resp_rdata=0. No mem_read or mem_write_en is asserted.
- States:
  - IDLE
  - RD: mem_read=1 for exactly one cycle; mem_read_data is registered at the end of the cycle.
  - MERGE: mem_read=1; the captured old word is merged.
  - WR: mem_write_en=1 for exactly one cycle.
  - RESP
- Transitions:
  - IDLE→RD (load).
  - IDLE→WR (SW).
  - IDLE→MERGE (SB/SH).
  - IDLE→RESP (error).
  - RD→RESP.
  - MERGE→WR.
  - WR→RESP.
  - RESP→IDLE when resp_ready=1; otherwise hold all resp_* outputs stable.
- mem_access_addr is stable for the whole RD/MERGE/WR span. mem_read and mem_write_en are never both 1.
- Latency, accept edge = cycle 0, resp_valid first high in cycle N:
  - load N=2;
  - SW N=2;
  - SB/SH N=3;
  - error N=1.
- Load extraction:
  - byte lane = ea[1:0]*8; half lane = ea[1]*16.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Store merge:
  - SB replaces byte lane ea[1:0] of the old word with req_wdata[7:0].
  - SH replaces halfword lane ea[1] with req_wdata[15:0].
  - SW writes req_wdata unchanged.
- Back-to-back: the earliest next accept is the cycle after the RESP handshake. There is no overlap of requests.

Test Plan:
- Memory word 3 = 0x80FF_1234. LB base=0x0C off=1: resp at cycle 2, resp_rdata=0x0000_0012. LBU off=3: 0x0000_0080. LB off=3: 0xFFFF_FF80. LH off=2: 0xFFFF_80FF.
- SW base=0x10 off=-4 wdata=0xDEAD_BEEF: mem_write_en pulses one cycle with mem_access_addr=3. Word 3 becomes 0xDEAD_BEEF. resp_valid at cycle 2, resp_err=0.
- Word 5 = 0x1122_3344. SH ea=0x16 wdata=0xAAAA_5566: MERGE then WR. Word 5 becomes 0x5566_3344. resp_valid at cycle 3.
- LW ea=0x06: resp_err=1 at cycle 1; mem_read and mem_write_en stay 0. SW ea=4*DEPTH_WORDS: resp_err=1; memory unchanged.
- Hold resp_ready=0 for 4 cycles after a load response: resp_rdata/resp_rd stable and req_ready=0. Release → IDLE next cycle; the following request is accepted.
- Assert rst_n=0 during MERGE of an SB: all outputs go to reset values immediately; target word unchanged; req_ready=1 after release.

Source files
------------

// File: rtl/dmem_lsu.sv
// Load/store initiator for a word-wide data memory; load/SW respond in 2 cycles, SB/SH in 3, errors in 1.
// One request in flight: req_ready only in IDLE, and the response is held until resp_ready.
module dmem_lsu #(
    parameter int DEPTH_WORDS = 32,
    parameter int IDX_W       = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_base,
    input  logic [11:0] req_offset,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic [4:0]  resp_rd,
    output logic        resp_err,
    output logic [31:0] mem_access_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_write_en,
    output logic        mem_read,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_MERGE,
        S_WR,
        S_RESP
    } state_t;

    typedef struct packed {
        logic [2:0]  funct3;
        logic [1:0]  lane;
        logic [31:0] wdata;
        logic [4:0]  rd;
    } req_t;

    state_t      state_q;
    req_t        req_q;
    logic        req_ready_q;
    logic        resp_valid_q;
    logic        resp_err_q;
    logic [31:0] resp_rdata_q;
    logic [4:0]  resp_rd_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic        mem_we_q;
    logic        mem_rd_q;

    logic [31:0] ea;
    logic        ill_f3;
    logic        misal;
    logic        oor;
    logic        acc_err;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] rdata_d;
    logic [31:0] wword_d;

    // Accept-time decode straight from the request inputs.
    always_comb begin
        ea = req_base + {{20{req_offset[11]}}, req_offset};
        if (req_we) begin
            ill_f3 = req_funct3[2] || (req_funct3[1:0] == 2'b11);
        end else begin
            ill_f3 = (req_funct3[1:0] == 2'b11) || (req_funct3 == 3'b110);
        end
        misal   = ((req_funct3[1:0] == 2'b01) && ea[0]) ||
                  ((req_funct3[1:0] == 2'b10) && (ea[1:0] != 2'b00));
        oor     = (|ea[31:IDX_W+2]) || (32'(ea[IDX_W+1:2]) >= 32'(DEPTH_WORDS));
        acc_err = ill_f3 || misal || oor;
    end

    // Lane extraction for loads and lane replacement for sub-word stores.
    always_comb begin
        byte_v = mem_read_data[{req_q.lane, 3'b000} +: 8];
        half_v = req_q.lane[1] ? mem_read_data[31:16] : mem_read_data[15:0];
        case (req_q.funct3)
            3'b000:  rdata_d = {{24{byte_v[7]}}, byte_v};
            3'b001:  rdata_d = {{16{half_v[15]}}, half_v};
            3'b010:  rdata_d = mem_read_data;
            3'b100:  rdata_d = {24'h0, byte_v};
            3'b101:  rdata_d = {16'h0, half_v};
            default: rdata_d = 32'h0;
        endcase
        wword_d = mem_read_data;
        case (req_q.funct3[1:0])
            2'b00: wword_d[{req_q.lane, 3'b000} +: 8] = req_q.wdata[7:0];
            2'b01: begin
                if (req_q.lane[1]) begin
                    wword_d[31:16] = req_q.wdata[15:0];
                end else begin
                    wword_d[15:0] = req_q.wdata[15:0];
                end
            end
            default: wword_d = req_q.wdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            req_q        <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_rd_q    <= 5'h0;
            mem_addr_q   <= 32'h0;
            mem_wdata_q  <= 32'h0;
            mem_we_q     <= 1'b0;
            mem_rd_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        req_ready_q <= 1'b0;
                        req_q       <= '{funct3: req_funct3, lane: ea[1:0],
                                         wdata: req_wdata, rd: req_rd};
                        mem_addr_q  <= {2'b00, ea[31:2]};
                        if (acc_err) begin
                            state_q      <= S_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= 32'h0;
                            resp_rd_q    <= req_rd;
                        end else if (!req_we) begin
                            state_q  <= S_RD;
                            mem_rd_q <= 1'b1;
                        end else if (req_funct3[1:0] == 2'b10) begin
                            state_q     <= S_WR;
                            mem_we_q    <= 1'b1;
                            mem_wdata_q <= req_wdata;
                        end else begin
                            state_q  <= S_MERGE;
                            mem_rd_q <= 1'b1;
                        end
                    end
                end
                S_RD: begin
                    state_q      <= S_RESP;
                    mem_rd_q     <= 1'b0;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= rdata_d;
                    resp_rd_q    <= req_q.rd;
                end
                S_MERGE: begin
                    state_q     <= S_WR;
                    mem_rd_q    <= 1'b0;
                    mem_we_q    <= 1'b1;
                    mem_wdata_q <= wword_d;
                end
                S_WR: begin
                    state_q      <= S_RESP;
                    mem_we_q     <= 1'b0;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= 32'h0;
                    resp_rd_q    <= req_q.rd;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        state_q      <= S_IDLE;
                        resp_valid_q <= 1'b0;
                        resp_err_q   <= 1'b0;
                        req_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    req_ready_q <= 1'b1;
                    mem_rd_q    <= 1'b0;
                    mem_we_q    <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready       = req_ready_q;
    assign resp_valid      = resp_valid_q;
    assign resp_err        = resp_err_q;
    assign resp_rdata      = resp_rdata_q;
    assign resp_rd         = resp_rd_q;
    assign mem_access_addr = mem_addr_q;
    assign mem_write_data  = mem_wdata_q;
    assign mem_write_en    = mem_we_q;
    assign mem_read        = mem_rd_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Randomized bench for dmem_lsu against a byte-level reference model of the data memory.
module tb_dmem_lsu;

    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_base;
    logic [11:0] req_offset;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic        resp_err;
    logic [31:0] mem_access_addr;
    logic [31:0] mem_write_data;
    logic        mem_write_en;
    logic        mem_read;
    logic [31:0] mem_read_data;

    logic [31:0] mem     [DEPTH];
    logic [31:0] ref_mem [DEPTH];

    int errors = 0;
    int checks = 0;
    int excl_viol = 0;

    dmem_lsu #(.DEPTH_WORDS(DEPTH), .IDX_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_base(req_base), .req_offset(req_offset),
        .req_wdata(req_wdata), .req_rd(req_rd),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_rd(resp_rd), .resp_err(resp_err),
        .mem_access_addr(mem_access_addr), .mem_write_data(mem_write_data),
        .mem_write_en(mem_write_en), .mem_read(mem_read), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    assign mem_read_data = (mem_access_addr < 32'(DEPTH)) ? mem[mem_access_addr[4:0]] : 32'h0;

    always @(posedge clk) begin
        if (mem_write_en && (mem_access_addr < 32'(DEPTH))) begin
            mem[mem_access_addr[4:0]] <= mem_write_data;
        end
    end

    always @(negedge clk) begin
        if (rst_n && mem_read && mem_write_en) excl_viol++;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        check({tag, "_resp_err"}, 32'(resp_err), 32'd0);
        check({tag, "_resp_rdata"}, resp_rdata, 32'd0);
        check({tag, "_resp_rd"}, 32'(resp_rd), 32'd0);
        check({tag, "_addr"}, mem_access_addr, 32'd0);
        check({tag, "_wdata"}, mem_write_data, 32'd0);
        check({tag, "_we"}, 32'(mem_write_en), 32'd0);
        check({tag, "_rd_en"}, 32'(mem_read), 32'd0);
    endtask

    // Reference: byte-addressed semantics computed directly from ea, size and signedness.
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] base,
                         input logic [11:0] off, input logic [31:0] wd,
                         output logic [31:0] exp_rdata, output logic exp_err,
                         output int lat, output int nrd, output int nwr,
                         output int idx, output logic [31:0] new_word);
        int          soff;
        int          size;
        int          shift;
        logic [31:0] ea;
        logic [31:0] word;
        logic [31:0] mask;
        logic [31:0] v;
        bit          legal;
        soff  = int'($signed(off));
        ea    = base + 32'(soff);
        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        idx   = int'(ea / 32'd4);
        shift = 8 * int'(ea % 32'd4);
        mask  = (size == 4) ? 32'hFFFF_FFFF : (((32'd1 << (8 * size)) - 32'd1) << shift);
        exp_rdata = 32'h0;
        new_word  = 32'h0;
        exp_err   = !legal || ((ea % 32'(size)) != 32'd0) || ((ea / 32'd4) >= 32'(DEPTH));
        if (exp_err) begin
            lat = 1; nrd = 0; nwr = 0;
        end else if (!we) begin
            word = ref_mem[idx];
            v    = (word & mask) >> shift;
            if (size < 4 && !f3[2] && v[8 * size - 1]) v = v | ~(mask >> shift);
            exp_rdata = v;
            lat = 2; nrd = 1; nwr = 0;
        end else begin
            word     = ref_mem[idx];
            new_word = (word & ~mask) | ((wd << shift) & mask);
            ref_mem[idx] = new_word;
            lat = (size == 4) ? 2 : 3;
            nrd = (size == 4) ? 0 : 1;
            nwr = 1;
        end
    endtask

    // Called and returns at posedge+1 with the DUT idle.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] base,
                          input logic [11:0] off, input logic [31:0] wd,
                          input logic [4:0] rd, input int hold);
        logic [31:0] exp_rdata;
        logic [31:0] new_word;
        logic [31:0] wr_addr;
        logic [31:0] wr_data;
        logic        exp_err;
        int          lat_exp;
        int          nrd_exp;
        int          nwr_exp;
        int          idx;
        int          lat;
        int          nrd;
        int          nwr;
        model(we, f3, base, off, wd, exp_rdata, exp_err, lat_exp, nrd_exp, nwr_exp, idx, new_word);
        check("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_base   = base;
        req_offset = off;
        req_wdata  = wd;
        req_rd     = rd;
        resp_ready = (hold == 0);
        @(posedge clk); #1;
        req_valid  = 1'b0;
        req_base   = $urandom;
        req_wdata  = $urandom;
        req_rd     = 5'($urandom);
        lat = 1; nrd = 0; nwr = 0; wr_addr = 32'h0; wr_data = 32'h0;
        while (!resp_valid && lat < 10) begin
            if (mem_read) nrd++;
            if (mem_write_en) begin
                nwr++;
                wr_addr = mem_access_addr;
                wr_data = mem_write_data;
            end
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(lat_exp));
        check("mem_read_cycles", 32'(nrd), 32'(nrd_exp));
        check("mem_write_cycles", 32'(nwr), 32'(nwr_exp));
        check("resp_err", 32'(resp_err), 32'(exp_err));
        check("resp_rdata", resp_rdata, exp_rdata);
        check("resp_rd", 32'(resp_rd), 32'(rd));
        if (nwr_exp == 1) begin
            check("write_addr", wr_addr, 32'(idx));
            check("write_data", wr_data, new_word);
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(resp_valid), 32'd1);
            check("hold_rdata", resp_rdata, exp_rdata);
            check("hold_rd", 32'(resp_rd), 32'(rd));
            check("hold_req_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        check("post_hs_valid", 32'(resp_valid), 32'd0);
        check("post_hs_ready", 32'(req_ready), 32'd1);
        if (nwr_exp == 1) check("mem_word", mem[idx], ref_mem[idx]);
    endtask

    initial begin
        int          diffs;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] base;
        logic [11:0] off;

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_base = 32'h0; req_offset = 12'h0; req_wdata = 32'h0; req_rd = 5'd0;
        resp_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[3] = 32'h80FF_1234; ref_mem[3] = 32'h80FF_1234;
        mem[5] = 32'h1122_3344; ref_mem[5] = 32'h1122_3344;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_req(1'b0, 3'b000, 32'h0C, 12'd1, 32'h0, 5'd1, 0);
        do_req(1'b0, 3'b100, 32'h0C, 12'd3, 32'h0, 5'd2, 0);
        do_req(1'b0, 3'b000, 32'h0C, 12'd3, 32'h0, 5'd3, 0);
        do_req(1'b0, 3'b001, 32'h0C, 12'd2, 32'h0, 5'd4, 0);
        do_req(1'b0, 3'b101, 32'h0C, 12'd2, 32'h0, 5'd5, 0);
        do_req(1'b0, 3'b010, 32'h0C, 12'd0, 32'h0, 5'd6, 0);
        do_req(1'b1, 3'b010, 32'h10, 12'hFFC, 32'hDEAD_BEEF, 5'd7, 0);
        check("word3_sw", mem[3], 32'hDEAD_BEEF);
        do_req(1'b1, 3'b001, 32'h16, 12'd0, 32'hAAAA_5566, 5'd8, 0);
        check("word5_sh", mem[5], 32'h5566_3344);
        do_req(1'b1, 3'b000, 32'h14, 12'd1, 32'h0000_00C3, 5'd9, 0);
        do_req(1'b0, 3'b010, 32'h06, 12'd0, 32'h0, 5'd10, 0);
        do_req(1'b0, 3'b001, 32'h05, 12'd0, 32'h0, 5'd11, 0);
        do_req(1'b1, 3'b010, 32'(4 * DEPTH), 12'd0, 32'h1234_5678, 5'd12, 0);
        do_req(1'b0, 3'b000, 32'(4 * DEPTH), 12'hFFF, 32'h0, 5'd13, 0);
        do_req(1'b0, 3'b011, 32'h08, 12'd0, 32'h0, 5'd14, 0);
        do_req(1'b1, 3'b100, 32'h08, 12'd0, 32'hFFFF_FFFF, 5'd15, 0);
        do_req(1'b0, 3'b000, 32'h0C, 12'd1, 32'h0, 5'd16, 4);

        for (int n = 0; n < 80; n++) begin
            we = 1'($urandom);
            if ($urandom_range(0, 3) == 0) f3 = 3'($urandom);
            else f3 = we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5));
            if ($urandom_range(0, 9) == 0) base = $urandom;
            else base = 32'($urandom_range(0, 4 * DEPTH + 8));
            off = 12'($urandom_range(0, 40) - 20);
            do_req(we, f3, base, off, $urandom, 5'($urandom), int'($urandom_range(0, 2)));
        end

        // Reset during the MERGE cycle of an SB must not let the write through.
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
        req_base = 32'h20; req_offset = 12'd2; req_wdata = 32'h0000_005A; req_rd = 5'd3;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("merge_read", 32'(mem_read), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midreset_word", mem[8], ref_mem[8]);
        do_req(1'b0, 3'b010, 32'h20, 12'd0, 32'h0, 5'd17, 0);

        diffs = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) diffs++;
        check("mem_image", 32'(diffs), 32'd0);
        check("rd_wr_exclusive", 32'(excl_viol), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
